// File: rtl/median_win_ctrl.sv
// rtl/median_win_ctrl.sv - 3x3 median window sequencer between source RAM, median core and destination RAM
// Optional build macro MEDCTRL_BORDER_ZERO_EN: border pixels write 0 without reading the source.
module median_win_ctrl #(
  parameter int PIX_W    = 8,
  parameter int WIDTH    = 8,
  parameter int HEIGHT   = 8,
  parameter int ADDR_W   = 16,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 1024
) (
  input  logic               clka,
  input  logic               reset,
  input  logic               start,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [PIX_W-1:0]   rd_data,
  output logic               win_valid,
  output logic [9*PIX_W-1:0] win_data,
  input  logic               med_valid,
  input  logic [PIX_W-1:0]   med_data,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIX_W-1:0]   wr_data,
  output logic               busy,
  output logic               done
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0]     X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] SRC_A  = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A  = ADDR_W'(DST_BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_MED, S_BORDER, S_WRITE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [XW-1:0]      x_q, x_d, nx;
  logic [YW-1:0]      y_q, y_d, ny;
  logic [9*PIX_W-1:0] win_data_q, win_data_d;
  logic               win_valid_q, win_valid_d;
  logic [PIX_W-1:0]   res_q, res_d;
  logic               done_q, done_d;

  logic [ADDR_W-1:0]  pix_off, centre_a, dst_a, win_row, win_col, fetch_a;

  function automatic logic is_border(input logic [XW-1:0] px, input logic [YW-1:0] py);
    return (px == '0) || (px == X_LAST) || (py == '0) || (py == Y_LAST);
  endfunction

  function automatic state_t entry_state(input logic [XW-1:0] px, input logic [YW-1:0] py);
    if (!is_border(px, py)) return S_FETCH;
`ifdef MEDCTRL_BORDER_ZERO_EN
    return S_WRITE;
`else
    return S_BORDER;
`endif
  endfunction

  // Window tap k sits at row k/3, column k%3 relative to the top-left neighbour.
  always_comb begin
    pix_off  = ADDR_W'(y_q) * W_A + ADDR_W'(x_q);
    centre_a = SRC_A + pix_off;
    dst_a    = DST_A + pix_off;
    win_row  = '0;
    win_col  = ADDR_W'(cnt_q);
    if (cnt_q >= 4'd6) begin
      win_row = ADDR_W'(2);
      win_col = ADDR_W'(cnt_q - 4'd6);
    end else if (cnt_q >= 4'd3) begin
      win_row = ADDR_W'(1);
      win_col = ADDR_W'(cnt_q - 4'd3);
    end
    fetch_a = centre_a + win_row * W_A + win_col - W_A - ADDR_W'(1);
  end

  always_comb begin
    nx = (x_q == X_LAST) ? '0 : x_q + XW'(1);
    ny = (x_q == X_LAST) ? y_q + YW'(1) : y_q;
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
      res_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      win_data_q  <= win_data_d;
      win_valid_q <= win_valid_d;
      res_q       <= res_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    win_data_d  = win_data_q;
    win_valid_d = 1'b0;
    res_d       = res_q;
    done_d      = done_q;
    rd_en       = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          res_d   = '0;
          done_d  = 1'b0;
          state_d = entry_state('0, '0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (cnt_q < 4'd9) begin
          rd_en   = 1'b1;
          rd_addr = fetch_a;
        end
        // Read data lags its strobe by one cycle, so slot k lands at count k+1.
        for (int k = 0; k < 9; k++) begin
          if (cnt_q == 4'(k + 1)) win_data_d[k*PIX_W +: PIX_W] = rd_data;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          state_d     = S_WAIT_MED;
          win_valid_d = 1'b1;
        end
      end
      S_WAIT_MED: begin
        if (med_valid) begin
          res_d   = med_data;
          state_d = S_WRITE;
        end
      end
      S_BORDER: begin
        if (cnt_q == 4'd0) begin
          rd_en   = 1'b1;
          rd_addr = centre_a;
          cnt_d   = 4'd1;
        end else begin
          res_d   = rd_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = dst_a;
        wr_data = res_q;
        if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          x_d     = nx;
          y_d     = ny;
          cnt_d   = '0;
          res_d   = '0;
          state_d = entry_state(nx, ny);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = done_q;

endmodule

// File: doc/median_win_ctrl.md
Name: median_win_ctrl

Overview:
Sequencer for the 3x3 median filter datapath. Raster-scans an image held in source RAM, fetches each 3x3 window, hands it to the median datapath, and writes the returned median to destination RAM. Border pixels bypass the median datapath. Signals overall completion via `done`, sitting between the RAM instance and the median core at the top level.

Parameters:
PIX_W, 8, pixel width in bits
WIDTH, 8, image width in pixels (>=3)
HEIGHT, 8, image height in pixels (>=3)
ADDR_W, 16, RAM address width
SRC_BASE, 0, source image base word address
DST_BASE, 1024, destination image base word address

Ports:
clka  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, begins a frame when idle
rd_en  out  1  source RAM read strobe
rd_addr  out  ADDR_W  source RAM read address
rd_data  in  PIX_W  source RAM data, valid 1 cycle after rd_en
win_valid  out  1  one-cycle pulse, win_data holds complete window
win_data  out  9*PIX_W  window, pixel k at [k*PIX_W +: PIX_W], k=3*(dy+1)+(dx+1)
med_valid  in  1  median datapath result strobe
med_data  in  PIX_W  median result
wr_en  out  1  destination RAM write strobe
wr_addr  out  ADDR_W  destination write address
wr_data  out  PIX_W  destination write data
busy  out  1  high from accepted start until frame complete
done  out  1  level, high after last write until next accepted start or reset

Behaviour:
- Reset (synchronous, active-high): state IDLE, x=y=0. All outputs 0: rd_en, rd_addr, win_valid, win_data, wr_en, wr_addr, wr_data, busy, done. Reset mid-frame aborts immediately. No further RAM access.
- States: IDLE, FETCH, WAIT_MED, BORDER, WRITE, DONE.
- IDLE: start=1 -> x=y=0, busy=1, done=0, go to FETCH or BORDER depending on pixel (0,0). start is ignored while busy.
- Addressing: src = SRC_BASE + y*WIDTH + x (+dy*WIDTH+dx). dst = DST_BASE + y*WIDTH + x. Computed modulo 2^ADDR_W.
- Border pixel: x==0, x==WIDTH-1, y==0 or y==HEIGHT-1.
- BORDER: one read of centre pixel, captured next cycle. wr_en the cycle after capture with wr_data=centre. Total 3 cycles per border pixel.
- FETCH (interior): rd_en high on 9 consecutive cycles T..T+8, k=0..8 in raster order (dy=-1..1 outer, dx=-1..1 inner). Data captured into win_data slot k at T+1..T+9. win_valid=1 at T+10 only, then WAIT_MED.
- WAIT_MED: waits indefinitely for med_valid. med_valid outside WAIT_MED is ignored. On med_valid, latch med_data, go to WRITE.
- WRITE: wr_en=1 for exactly one cycle with dst address/data.
- Advance: the cycle after the write, x increments. At x==WIDTH-1, x=0 and y increments. After pixel (WIDTH-1, HEIGHT-1), enter DONE.
- DONE: busy=0, done=1, go to IDLE. done stays 1. A start in DONE/IDLE restarts the frame and clears done on the same edge.
- win_data holds its value between windows. rd_en and wr_en are never high in the same cycle.

Optional Feature:
MEDCTRL_BORDER_ZERO_EN
- Defined: border pixels issue no read and write 0 in a single WRITE cycle (1 cycle per border pixel).
- Undefined: border pixels copy the source centre pixel as above.

Test Plan:
- Reset: assert reset mid-FETCH of pixel (1,1) on a 4x4 image -> next cycle all outputs 0, busy=0, no further rd_en/wr_en; new start runs a full frame.
- 4x4 frame, src[i]=i, median model returns win_data slot 4 after 3 cycles -> window (1,1) reads addresses 0,1,2,4,5,6,8,9,10 in order. win_valid exactly 10 cycles after first rd_en. Dst 1024..1039 = 0..15, exactly 16 writes, then done=1, busy=0.
- Border copy: 4x4, src[i]=i+100 -> dst[1024]=100, dst[1027]=103, dst[1036]=112. Each border pixel takes 3 cycles with no win_valid.
- Stalled median: hold med_valid low 50 cycles at pixel (2,1) -> controller stays in WAIT_MED, no rd_en/wr_en. Then med_valid=1, med_data=0xAB -> wr_en next cycle, wr_addr=1024+6, wr_data=0xAB.
- Start while busy and spurious med_valid during FETCH -> both ignored. Write count stays 16 and window contents are unchanged.
- With MEDCTRL_BORDER_ZERO_EN: 4x4 frame -> 12 border writes of 0 with no reads. Only 36 rd_en cycles total (4 interior x 9).
